// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back write-allocate cache with block-memory handshake
module dm_cache_ctrl #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int SETS = 1 << INDEX_W;
  typedef enum logic [2:0] {IDLE, WB, WB_REL, AL, AL_REL} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [127:0] data_q [SETS];
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [27:0] mem_addr_q, mem_addr_d, miss_addr_q, miss_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [INDEX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] atag, ftag;
  logic [1:0] off;
  logic req, hit, fill, whit;
  assign off  = proc_addr[1:0];
  assign idx  = proc_addr[INDEX_W+1:2];
  assign atag = proc_addr[29:INDEX_W+2];
  assign fidx = miss_addr_q[INDEX_W-1:0];
  assign ftag = miss_addr_q[27:INDEX_W];
  assign req  = proc_read | proc_write;
  assign hit  = req & valid_q[idx] & (tag_q[idx] == atag);
  assign fill = (state_q == AL) & mem_ready;
  assign whit = (state_q == IDLE) & proc_write & hit;
  assign proc_stall = req & ~((state_q == IDLE) & hit);
  assign proc_rdata = ((state_q == IDLE) & hit) ? data_q[idx][{off, 5'b0} +: 32] : 32'h0;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // next-state and registered memory-request decode; the miss address is latched so a
  // request dropped mid-transaction still fills the block that was originally missed
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    case (state_q)
      IDLE: if (req && !hit) begin
        miss_addr_d = proc_addr[29:2];
        if (valid_q[idx] && dirty_q[idx]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {tag_q[idx], idx};
          mem_wdata_d = data_q[idx];
          state_d     = WB;
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = proc_addr[29:2];
          state_d    = AL;
        end
      end
      WB: if (mem_ready) begin
        mem_write_d = 1'b0;
        state_d     = WB_REL;
      end
      WB_REL: if (!mem_ready) begin
        mem_read_d = 1'b1;
        mem_addr_d = miss_addr_q;
        state_d    = AL;
      end
      AL: if (mem_ready) begin
        mem_read_d = 1'b0;
        state_d    = AL_REL;
      end
      AL_REL: state_d = mem_ready ? AL_REL : IDLE;
      default: state_d = IDLE;
    endcase
    if (fill) begin
      valid_d[fidx] = 1'b1;
      dirty_d[fidx] = 1'b0;
    end
    if (whit) dirty_d[idx] = 1'b1;
  end
  // control state with synchronous reset; reset invalidates every block
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_addr_q <= miss_addr_d;
    end
  end
  // tag and data arrays: block fill from memory or single-word write hit
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fidx] <= mem_rdata;
      tag_q[fidx]  <= ftag;
    end else if (whit) data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed self-checking bench for dm_cache_ctrl
module tb_dm_cache_ctrl;
  logic clk = 1'b0;
  logic proc_reset, proc_read, proc_write, mem_ready;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata, proc_rdata;
  logic proc_stall, mem_read, mem_write;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic serve(input bit wr, input logic [27:0] a, input logic [127:0] wd,
                       input logic [127:0] rd, input int hold);
    int n = 0;
    while (!(wr ? mem_write : mem_read) && n < 20) begin
      step();
      n++;
    end
    chk(wr ? "wb_req" : "al_req", wr ? mem_write : mem_read, 1);
    chk("other_req_low", wr ? mem_read : mem_write, 0);
    chk("mem_addr", mem_addr, a);
    if (wr) chk("mem_wdata", mem_wdata, wd);
    chk("stall_in_miss", proc_stall, 1);
    step();
    chk("req_held", wr ? mem_write : mem_read, 1);
    chk("addr_held", mem_addr, a);
    mem_rdata = rd;
    mem_ready = 1'b1;
    step();
    chk("req_dropped", mem_read | mem_write, 0);
    repeat (hold) begin
      step();
      chk("stale_ready_idle", mem_read | mem_write, 0);
      chk("stale_ready_stall", proc_stall, 1);
    end
    mem_ready = 1'b0;
  endtask

  always @(negedge clk) if (!proc_reset) chk("rd_wr_exclusive", mem_read & mem_write, 0);

  initial begin
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_no_stall", proc_stall, 0);
    proc_reset = 1'b0;
    proc_read = 1'b1; proc_addr = 30'h00;
    #1;
    chk("cold_miss_stall", proc_stall, 1);
    chk("cold_miss_rdata", proc_rdata, 0);
    serve(1'b0, 28'h0, '0, {32'h4, 32'h3, 32'h2, 32'h1}, 1);
    step();
    chk("fill_stall", proc_stall, 0);
    chk("fill_rdata", proc_rdata, 32'h1);
    proc_addr = 30'h02;
    #1;
    chk("hit_stall", proc_stall, 0);
    chk("hit_rdata", proc_rdata, 32'h3);
    step();
    chk("hit_no_mem_read", mem_read, 0);
    proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h01; proc_wdata = 32'hDEADBEEF;
    #1;
    chk("whit_stall", proc_stall, 0);
    step();
    chk("whit_no_mem_write", mem_write, 0);
    proc_write = 1'b0; proc_read = 1'b1;
    #1;
    chk("whit_readback", proc_rdata, 32'hDEADBEEF);
    proc_addr = 30'h20;
    #1;
    chk("dirty_miss_stall", proc_stall, 1);
    serve(1'b1, 28'h0, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1}, '0, 4);
    serve(1'b0, 28'h8, '0, {32'h8, 32'h7, 32'h6, 32'h5}, 1);
    step();
    chk("refill_stall", proc_stall, 0);
    chk("refill_rdata", proc_rdata, 32'h5);
    proc_addr = 30'h1F;
    #1;
    chk("top_idx_miss", proc_stall, 1);
    serve(1'b0, 28'h7, '0, {32'hD, 32'hC, 32'hB, 32'hA}, 1);
    step();
    chk("top_idx_rdata", proc_rdata, 32'hD);
    proc_addr = 30'h3F;
    #1;
    chk("top_idx_alias_miss", proc_stall, 1);
    serve(1'b0, 28'hF, '0, {32'h14, 32'h13, 32'h12, 32'h11}, 1);
    step();
    chk("top_idx_tag1_rdata", proc_rdata, 32'h14);
    proc_addr = 30'h02;
    #1;
    chk("idx0_tag0_miss", proc_stall, 1);
    serve(1'b0, 28'h0, '0, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1}, 1);
    step();
    chk("idx0_tag0_rdata", proc_rdata, 32'h3);
    proc_addr = 30'h1F;
    step();
    chk("pre_reset_al", mem_read, 1);
    proc_reset = 1'b1;
    step();
    chk("reset_drops_read", mem_read, 0);
    proc_reset = 1'b0; proc_addr = 30'h02;
    #1;
    chk("post_reset_miss", proc_stall, 1);
    chk("post_reset_rdata", proc_rdata, 0);
    serve(1'b0, 28'h0, '0, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1}, 1);
    step();
    chk("post_reset_refill", proc_rdata, 32'h3);
    proc_read = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
